// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer.
// Normal ops take 32 iterations: shift-add for multiply, restoring
// shift-subtract for divide. The core works on unsigned magnitudes and the
// sign is applied at completion. Divide-by-zero and signed overflow are
// resolved when the op is accepted and go straight to DONE.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [2:0]           f3_q, f3_d;
    logic [WIDTH-1:0]     srca_q, srca_d;
    logic [WIDTH-1:0]     srcb_q, srcb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     pend_q, pend_d;    // value to publish in DONE
    logic [WIDTH-1:0]     result_q, result_d;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic a_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == 3'b001 || f3 == 3'b010);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic b_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 == 3'b001);
    endfunction

    // Acceptance decode on the live inputs
    logic             accept, in_div0, in_ovf, special;
    logic             in_a_neg, in_b_neg;
    logic [WIDTH-1:0] in_a_mag, in_b_mag, special_val;

    always_comb begin
        accept      = (state_q == IDLE) && start && !flush;
        in_div0     = funct3[2] && (srcb == '0);
        in_ovf      = funct3[2] && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
        special     = in_div0 || in_ovf;
        in_a_neg    = srca[WIDTH-1] && a_signed(funct3);
        in_b_neg    = srcb[WIDTH-1] && b_signed(funct3);
        in_a_mag    = in_a_neg ? -srca : srca;
        in_b_mag    = in_b_neg ? -srcb : srcb;
        // REM* keeps the dividend on /0 and yields 0 on overflow
        if (in_div0)
            special_val = funct3[1] ? srca : '1;
        else
            special_val = funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration step on the latched operands plus the signed fix-up
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] iter_next, prod;
    logic [WIDTH-1:0] quo_f, rem_f, final_val;

    always_comb begin
        a_neg   = srca_q[WIDTH-1] && a_signed(f3_q);
        b_neg   = srcb_q[WIDTH-1] && b_signed(f3_q);
        a_mag   = a_neg ? -srca_q : srca_q;
        b_mag   = b_neg ? -srcb_q : srcb_q;
        // multiply: low half holds the multiplier, shifted out LSB first
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag} : '0);
        // divide: high half is the partial remainder, low half dividend/quotient
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, b_mag};
        if (f3_q[2])
            iter_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
        else
            iter_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod  = (a_neg ^ b_neg) ? -iter_next : iter_next;
        quo_f = (a_neg ^ b_neg) ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
        rem_f = a_neg ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
        case (f3_q)
            3'b000:                 final_val = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_val = quo_f;
            default:                final_val = rem_f;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; flush beats completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : RUN;
            RUN:     if (flush) state_d = IDLE;
                     else if (cnt_q == 5'd31) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch on accept, iterate in RUN, commit in DONE
    always_comb begin
        f3_d     = f3_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        result_d = result_q;
        if (accept) begin
            f3_d   = funct3;
            srca_d = srca;
            srcb_d = srcb;
            cnt_d  = '0;
            acc_d  = {{WIDTH{1'b0}}, funct3[2] ? in_a_mag : in_b_mag};
            if (special) pend_d = special_val;
        end else if (state_q == RUN && !flush) begin
            acc_d = iter_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) pend_d = final_val;
        end else if (state_q == DONE && !flush) begin
            result_d = pend_q;
        end
    end

    // Outputs; a flushed DONE shows neither the pulse nor the new value
    always_comb begin
        stall  = accept || (state_q == RUN);
        busy   = (state_q != IDLE);
        done   = (state_q == DONE) && !flush;
        result = done ? pend_q : result_q;
    end

endmodule
